// File: rtl/thread_register_file.sv
// Per-thread register file: R0-R12 general purpose, R13-R15 read-only specials
// (%blockIdx, %blockDim, %threadIdx). Registered rs/rt operands, writeback at UPDATE.
module thread_register_file #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_ID         = 0,
    parameter int DATA_BITS         = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [7:0]           block_id,
    input  logic [2:0]           core_state,
    input  logic [3:0]           decoded_rd_address,
    input  logic [3:0]           decoded_rs_address,
    input  logic [3:0]           decoded_rt_address,
    input  logic                 decoded_reg_write_enable,
    input  logic [1:0]           decoded_reg_input_mux,
    input  logic [DATA_BITS-1:0] decoded_immediate,
    input  logic [DATA_BITS-1:0] alu_out,
    input  logic [DATA_BITS-1:0] lsu_out,
    output logic [DATA_BITS-1:0] rs,
    output logic [DATA_BITS-1:0] rt
);

    localparam int unsigned NUM_REGS  = 16;
    localparam int unsigned LAST_GP   = 12;
    localparam int unsigned BLOCK_IDX = 13;
    localparam int unsigned BLOCK_DIM = 14;
    localparam int unsigned THREAD_IX = 15;

    localparam logic [2:0] ST_REQUEST = 3'b011;
    localparam logic [2:0] ST_UPDATE  = 3'b110;

    localparam logic [1:0] MUX_ALU = 2'b00;
    localparam logic [1:0] MUX_LSU = 2'b01;
    localparam logic [1:0] MUX_IMM = 2'b10;

    logic [DATA_BITS-1:0] regs [NUM_REGS];

    logic                 wr_en_c;
    logic [DATA_BITS-1:0] wr_data_c;

    // Writeback source select; reserved mux code and special destinations never write
    always_comb begin
        wr_en_c   = 1'b0;
        wr_data_c = '0;
        if (core_state == ST_UPDATE && decoded_reg_write_enable &&
            decoded_rd_address <= 4'(LAST_GP)) begin
            case (decoded_reg_input_mux)
                MUX_ALU: begin wr_en_c = 1'b1; wr_data_c = alu_out;           end
                MUX_LSU: begin wr_en_c = 1'b1; wr_data_c = lsu_out;           end
                MUX_IMM: begin wr_en_c = 1'b1; wr_data_c = decoded_immediate; end
                default: begin wr_en_c = 1'b0; wr_data_c = '0;                end
            endcase
        end
    end

    // Register array, special registers and operand latches
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(BLOCK_DIM); i++) begin
                regs[i] <= '0;
            end
            regs[BLOCK_DIM] <= DATA_BITS'(THREADS_PER_BLOCK);
            regs[THREAD_IX] <= DATA_BITS'(THREAD_ID);
            rs              <= '0;
            rt              <= '0;
        end else if (enable) begin
            regs[BLOCK_IDX] <= DATA_BITS'(block_id);
            if (core_state == ST_REQUEST) begin
                rs <= regs[decoded_rs_address];
                rt <= regs[decoded_rt_address];
            end
            if (wr_en_c) begin
                regs[decoded_rd_address] <= wr_data_c;
            end
        end
    end

endmodule

// File: tb/tb_thread_register_file.sv
// Directed bench for thread_register_file: vector table plus a mid-instruction reset sequence.
module tb_thread_register_file;

    localparam logic [2:0] S_IDLE = 3'b000, S_REQ = 3'b011, S_WAIT = 3'b100,
                           S_EXE  = 3'b101, S_UPD = 3'b110;

    logic       clk = 1'b0;
    logic       reset, enable;
    logic [7:0] block_id;
    logic [2:0] core_state;
    logic [3:0] rd_a, rs_a, rt_a;
    logic       we;
    logic [1:0] mux;
    logic [7:0] imm, alu, lsu;
    logic [7:0] rs, rt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] bid;
        logic [2:0] st;
        logic [3:0] rd;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       we;
        logic [1:0] mux;
        logic [7:0] imm;
        logic [7:0] alu;
        logic [7:0] lsu;
        logic       chk;
        logic [7:0] ers;
        logic [7:0] ert;
    } vec_t;

    vec_t vecs[$];

    thread_register_file #(
        .THREADS_PER_BLOCK(4),
        .THREAD_ID        (2),
        .DATA_BITS        (8)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .enable                  (enable),
        .block_id                (block_id),
        .core_state              (core_state),
        .decoded_rd_address      (rd_a),
        .decoded_rs_address      (rs_a),
        .decoded_rt_address      (rt_a),
        .decoded_reg_write_enable(we),
        .decoded_reg_input_mux   (mux),
        .decoded_immediate       (imm),
        .alu_out                 (alu),
        .lsu_out                 (lsu),
        .rs                      (rs),
        .rt                      (rt)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic e, input logic [7:0] b, input logic [2:0] s,
                       input logic [3:0] d, input logic [3:0] a, input logic [3:0] bb,
                       input logic w, input logic [1:0] m, input logic [7:0] i,
                       input logic [7:0] al, input logic [7:0] ls,
                       input logic c, input logic [7:0] xs, input logic [7:0] xt);
        vec_t v;
        v.rst = r; v.en = e; v.bid = b; v.st = s; v.rd = d; v.ra = a; v.rb = bb;
        v.we = w; v.mux = m; v.imm = i; v.alu = al; v.lsu = ls;
        v.chk = c; v.ers = xs; v.ert = xt;
        vecs.push_back(v);
    endtask

    // Drive one cycle at the falling edge, sample #1 after the rising edge
    task automatic apply(input vec_t v);
        @(negedge clk);
        reset = v.rst; enable = v.en; block_id = v.bid; core_state = v.st;
        rd_a = v.rd; rs_a = v.ra; rt_a = v.rb; we = v.we; mux = v.mux;
        imm = v.imm; alu = v.alu; lsu = v.lsu;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] ers, input logic [7:0] ert);
        checks++;
        if (rs !== ers) begin
            errors++;
            $display("FAIL %s rs: got %h expected %h", name, rs, ers);
        end
        checks++;
        if (rt !== ert) begin
            errors++;
            $display("FAIL %s rt: got %h expected %h", name, rt, ert);
        end
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; block_id = '0; core_state = S_IDLE;
        rd_a = '0; rs_a = '0; rt_a = '0; we = 1'b0; mux = '0;
        imm = '0; alu = '0; lsu = '0;

        //   rst en  bid    st     rd  rs  rt  we mux    imm    alu    lsu   chk ers    ert
        add(0, 1, 8'h00, S_IDLE, 0,  0,  0,  0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h00); // reset
        add(1, 1, 8'h03, S_REQ,  0, 14, 15,  0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 8'h04, 8'h02); // R14/R15
        add(1, 1, 8'h03, S_REQ,  0, 13,  0,  0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 8'h03, 8'h00); // R13
        add(1, 1, 8'h03, S_REQ,  0,  0, 12,  0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h00); // GP zero
        add(1, 1, 8'h03, S_UPD,  5,  9,  9,  1, 2'b00, 8'h00, 8'h0F, 8'h00, 1, 8'h00, 8'h00); // R5=alu
        add(1, 1, 8'h03, S_REQ,  0,  5,  0,  0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 8'h0F, 8'h00);
        add(1, 1, 8'h03, S_UPD,  1,  0,  0,  1, 2'b10, 8'hA5, 8'h11, 8'h22, 0, 8'h00, 8'h00); // R1=imm
        add(1, 1, 8'h03, S_UPD,  2,  0,  0,  1, 2'b01, 8'h33, 8'h44, 8'h3C, 0, 8'h00, 8'h00); // R2=lsu
        add(1, 1, 8'h03, S_UPD,  3,  0,  0,  1, 2'b11, 8'h77, 8'h77, 8'h77, 0, 8'h00, 8'h00); // mux 11
        add(1, 1, 8'h03, S_REQ,  0,  1,  2,  0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 8'hA5, 8'h3C);
        add(1, 1, 8'h03, S_REQ,  0,  3,  5,  0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h0F);
        add(1, 1, 8'h03, S_UPD, 14,  0,  0,  1, 2'b10, 8'h09, 8'h09, 8'h09, 0, 8'h00, 8'h00); // protected
        add(1, 1, 8'h03, S_UPD, 13,  0,  0,  1, 2'b10, 8'h09, 8'h09, 8'h09, 0, 8'h00, 8'h00);
        add(1, 1, 8'h03, S_UPD, 15,  0,  0,  1, 2'b00, 8'h09, 8'h09, 8'h09, 0, 8'h00, 8'h00);
        add(1, 1, 8'h03, S_EXE,  6,  0,  0,  1, 2'b10, 8'h66, 8'h66, 8'h66, 0, 8'h00, 8'h00); // wrong state
        add(1, 1, 8'h03, S_UPD,  7,  0,  0,  0, 2'b10, 8'h77, 8'h77, 8'h77, 0, 8'h00, 8'h00); // we=0
        add(1, 1, 8'h03, S_REQ,  0, 14, 15,  0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 8'h04, 8'h02);
        add(1, 1, 8'h03, S_REQ,  0,  6,  7,  0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h00);
        add(1, 1, 8'h03, S_REQ,  0, 13, 13,  0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 8'h03, 8'h03); // same addr
        add(1, 1, 8'h03, S_REQ,  0,  1,  2,  0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 8'hA5, 8'h3C);
        add(1, 0, 8'h09, S_REQ,  0,  5, 14,  0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 8'hA5, 8'h3C); // disabled
        add(1, 0, 8'h09, S_UPD,  7,  0,  0,  1, 2'b10, 8'h01, 8'h01, 8'h01, 1, 8'hA5, 8'h3C);
        add(1, 1, 8'h03, S_REQ,  0,  7, 13,  0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h03);
        add(1, 1, 8'h07, S_REQ,  0, 13,  0,  0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 8'h03, 8'h00); // R13 lag
        add(1, 1, 8'h07, S_REQ,  0, 13,  0,  0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 8'h07, 8'h00);
        add(1, 1, 8'h07, S_UPD, 12,  0,  0,  1, 2'b00, 8'h00, 8'hC3, 8'h00, 0, 8'h00, 8'h00); // R12 edge
        add(1, 1, 8'h07, S_REQ,  0, 12, 11,  0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 8'hC3, 8'h00);
        add(1, 1, 8'h07, S_WAIT, 0,  1,  2,  0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 8'hC3, 8'h00); // hold
        add(1, 1, 8'h07, S_EXE,  0,  1,  2,  0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 8'hC3, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            if (vecs[i].chk) check($sformatf("vec%0d", i), vecs[i].ers, vecs[i].ert);
        end

        // Reset landing on the UPDATE edge of an instruction writing R4
        begin
            vec_t v;
            v = '{rst: 1, en: 1, bid: 8'h07, st: S_UPD, rd: 4, ra: 0, rb: 0, we: 1, mux: 2'b10,
                  imm: 8'h55, alu: 8'h00, lsu: 8'h00, chk: 0, ers: 8'h00, ert: 8'h00};
            apply(v);
            v.st = S_REQ; v.we = 0; v.ra = 4; v.rb = 4;
            apply(v);
            check("mid_setup", 8'h55, 8'h55);
            v.st = S_EXE;
            apply(v);
            check("mid_exec_hold", 8'h55, 8'h55);
            v.rst = 0; v.st = S_UPD; v.we = 1; v.rd = 4; v.imm = 8'h11;
            apply(v);
            check("mid_reset", 8'h00, 8'h00);
            v.rst = 1; v.st = S_REQ; v.we = 0; v.ra = 4; v.rb = 14;
            apply(v);
            check("mid_after_r4_r14", 8'h00, 8'h04);
            v.ra = 12; v.rb = 15;
            apply(v);
            check("mid_after_r12_r15", 8'h00, 8'h02);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/thread_register_file.md
# thread_register_file

Per-thread register file for the miniGPU compute core: it is the source and destination end of the ALU datapath. It drives the ALU operands `rs`/`rt` and writes back results from the ALU, the LSU or the decoded immediate. It holds 16 registers: R0–R12 are general purpose, and R13–R15 are read-only special registers (%blockIdx, %blockDim, %threadIdx). One instance sits per thread, alongside that thread's ALU and LSU, and is sequenced by the core's `core_state`.

## Interface
- `THREADS_PER_BLOCK`, default 4: reset value of R14 (%blockDim).
- `THREAD_ID`, default 0: reset value of R15 (%threadIdx).
- `DATA_BITS`, default 8: register and operand width.
- `clk` in 1: the only clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low; `reset==0` at a rising `clk` edge resets the block.
- `enable` in 1: thread active; when 0, all state holds.
- `block_id` in 8: current block index; source of R13.
- `core_state` in 3: IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111.
- `decoded_rd_address` in 4: destination register.
- `decoded_rs_address` in 4: first source register.
- `decoded_rt_address` in 4: second source register.
- `decoded_reg_write_enable` in 1: instruction writes `rd`.
- `decoded_reg_input_mux` in 2: write source; 00 = `alu_out`, 01 = `lsu_out`, 10 = `decoded_immediate`, 11 = reserved (no write).
- `decoded_immediate` in DATA_BITS: constant operand.
- `alu_out` in DATA_BITS: ALU result.
- `lsu_out` in DATA_BITS: load data.
- `rs` out DATA_BITS: registered operand A to the ALU/LSU.
- `rt` out DATA_BITS: registered operand B to the ALU/LSU.

## Operation
- **Reset** (checked first, regardless of `enable`):
  - R0–R13 <= 0, R14 <= THREADS_PER_BLOCK, R15 <= THREAD_ID.
  - `rs` <= 0, `rt` <= 0.
- **`enable==1`, every cycle:** R13 <= `block_id`.
- **REQUEST (011):** `rs` <= R[`decoded_rs_address`], `rt` <= R[`decoded_rt_address`]. Any register 0–15 may be read. Reading the same address on both ports is legal.
- **UPDATE (110)** with `decoded_reg_write_enable==1`:
  - Write happens only if `decoded_rd_address` <= 12; then R[rd] <= source selected by `decoded_reg_input_mux`.
  - rd in 13..15: write silently dropped, special registers unchanged.
  - Mux 11: no write.
- **Other states:** no register writes; `rs`/`rt` hold.
- **`enable==0`:** nothing changes, including R13, `rs` and `rt`.
- **Width:** all values are DATA_BITS. `block_id` is truncated or zero-extended to DATA_BITS. No arithmetic is performed here.

## Timing
- **Read latency:** 1 cycle. `rs`/`rt` are valid on the cycle after the REQUEST edge and stay stable through WAIT, EXECUTE and UPDATE until the next REQUEST.
- **Write:** takes effect at the UPDATE edge and is visible to the next instruction's REQUEST. REQUEST and UPDATE never coincide, so no bypass path is needed.
- **R13:** lags `block_id` by one enabled cycle.
- **Reset mid-instruction** (e.g. during EXECUTE or UPDATE): that edge performs the reset only; a pending write is lost and `rs`/`rt` go to 0.
- **No combinational path** from any input to `rs`/`rt`.

## Test plan
- **Reset values:** hold `reset=0` for 1 edge with THREADS_PER_BLOCK=4, THREAD_ID=2, then release with `enable=1`, `block_id=3`. REQUEST with rs=14, rt=15 gives `rs`=4, `rt`=2. A later REQUEST with rs=13 gives `rs`=3. R0–R12 read 0.
- **ALU writeback then read:** UPDATE with rd=5, mux=00, `alu_out`=15, we=1, then REQUEST with rs=5, rt=0 gives `rs`=15, `rt`=0 one cycle after REQUEST.
- **Immediate and LSU sources:**
  - mux=10, imm=0xA5 into R1 → R1 reads 0xA5.
  - mux=01, `lsu_out`=0x3C into R2 → R2 reads 0x3C.
  - mux=11 into R3 → R3 stays 0.
- **Protected and illegal writes:**
  - UPDATE rd=14, imm=9 → R14 still 4.
  - we=1 with rd=6 in EXECUTE state → R6 unchanged.
  - we=0 in UPDATE → no change.
- **Enable gating:** with `enable=0` through REQUEST and UPDATE (rd=7, imm=1), `rs`/`rt` hold their prior values, R7 stays 0, and R13 ignores a `block_id` change.
- **Reset mid-operation:** after R4=0x55 and `rs`=0x55, assert `reset=0` on the UPDATE edge that writes R4=0x11. Result: R4=0, `rs`=0, `rt`=0, and the write is lost.
